// File: rtl/accel_pkg.sv
// Shared types and constants for the BCD-to-binary accelerometer sample converter.
package accel_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int SHIFTS_DEFAULT = 14;
    localparam int POS_LIMIT      = 511;
    localparam int NEG_LIMIT      = 512;

endpackage

// File: rtl/bcd_digit_adjust.sv
// One BCD digit correction step of reverse double-dabble: digits >= 8 drop by 3.
module bcd_digit_adjust (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd8) ? (digit_i - 4'd3) : digit_i;

endmodule

// File: rtl/decimal_to_binary.sv
// Converts four BCD digits plus sign into a 10-bit two's-complement sample and
// its packed sensor-register form, using SHIFTS iterations of reverse double-dabble.
module decimal_to_binary
    import accel_pkg::*;
#(
    parameter int SHIFTS = SHIFTS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  thousands,
    input  logic [3:0]  hundreds,
    input  logic [3:0]  tens,
    input  logic [3:0]  ones,
    input  logic        negative,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [9:0]  decimal_data,
    output logic [15:0] accel_data
);

    localparam int CW = $clog2(SHIFTS + 1);

    state_t        state_q, state_d;
    logic [15:0]   digits_q;
    logic [15:0]   bcd_q;
    logic [13:0]   bin_q;
    logic          neg_q;
    logic [CW-1:0] cnt_q;
    logic          done_q;
    logic          err_q;
    logic [9:0]    dec_q;
    logic [15:0]   acc_q;

    logic [29:0]   shifted;
    logic [15:0]   bcd_adj;
    logic [11:0]   mag;
    logic          digit_bad;
    logic          fin_err;
    logic [9:0]    fin_dec;
    logic [15:0]   fin_acc;

    assign shifted = {bcd_q, bin_q} >> 1;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_adj
            bcd_digit_adjust u_adj (
                .digit_i (shifted[14 + 4*gi +: 4]),
                .digit_o (bcd_adj[4*gi +: 4])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == CW'(SHIFTS - 1)) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        mag       = bin_q[13:2];
        digit_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (digits_q[4*i +: 4] > 4'd9) digit_bad = 1'b1;
        end
        fin_err = digit_bad
                | (!neg_q && (mag > 12'(POS_LIMIT)))
                | ( neg_q && (mag > 12'(NEG_LIMIT)));
        if (fin_err) begin
            fin_dec = 10'd0;
        end else if (neg_q) begin
            fin_dec = ~mag[9:0] + 10'd1;
        end else begin
            fin_dec = mag[9:0];
        end
        fin_acc = {fin_dec[2:0], 6'b000000, fin_dec[9:3]};
    end

    // Digits are captured only on an accepted start, so mid-conversion starts have no effect.
    always_ff @(posedge clk) begin
        if (reset) begin
            digits_q <= '0;
            bcd_q    <= '0;
            bin_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            dec_q    <= '0;
            acc_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        digits_q <= {thousands, hundreds, tens, ones};
                        bcd_q    <= {thousands, hundreds, tens, ones};
                        bin_q    <= '0;
                        neg_q    <= negative;
                        cnt_q    <= '0;
                        err_q    <= 1'b0;
                    end
                end
                SHIFT: begin
                    bcd_q <= bcd_adj;
                    bin_q <= shifted[13:0];
                    cnt_q <= cnt_q + CW'(1);
                end
                FINISH: begin
                    dec_q  <= fin_dec;
                    acc_q  <= fin_acc;
                    err_q  <= fin_err;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign done         = done_q;
    assign err          = err_q;
    assign decimal_data = dec_q;
    assign accel_data   = acc_q;

endmodule

// File: tb/tb_decimal_to_binary.sv
// Directed bench for decimal_to_binary with a queue scoreboard of expected results.
module tb_decimal_to_binary;

    logic        clk = 1'b0;
    logic        reset, start, negative;
    logic [3:0]  thousands, hundreds, tens, ones;
    logic        busy, done, err;
    logic [9:0]  decimal_data;
    logic [15:0] accel_data;

    typedef struct {
        logic [9:0]  dec;
        logic [15:0] acc;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   n_checks = 0;
    int   n_pass   = 0;

    decimal_to_binary dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .thousands    (thousands),
        .hundreds     (hundreds),
        .tens         (tens),
        .ones         (ones),
        .negative     (negative),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .decimal_data (decimal_data),
        .accel_data   (accel_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [15:0] d, input logic neg);
        exp_t e;
        int   v, m;
        logic bad;
        bad = (d[15:12] > 9) || (d[11:8] > 9) || (d[7:4] > 9) || (d[3:0] > 9);
        v = int'(d[15:12]) * 1000 + int'(d[11:8]) * 100 + int'(d[7:4]) * 10 + int'(d[3:0]);
        m = v / 4;
        e.err = bad || (!neg && m > 511) || (neg && m > 512);
        if (e.err)    e.dec = 10'd0;
        else if (neg) e.dec = 10'(-m);
        else          e.dec = 10'(m);
        e.acc = {e.dec[2:0], 6'b000000, e.dec[9:3]};
        return e;
    endfunction

    // Drives a one-cycle start; returns one negedge after the accepting edge.
    task automatic start_conv(input string tag, input logic [15:0] d, input logic neg);
        {thousands, hundreds, tens, ones} = d;
        negative = neg;
        start    = 1'b1;
        sb.push_back(model(d, neg));
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy_after_start"}, busy, 1);
    endtask

    // Waits for done (bounded), checks latency and pops the scoreboard; stays in the done cycle.
    task automatic wait_done(input string tag, input int from);
        int lat = 0;
        for (int i = from + 1; i <= 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        check({tag, " latency"}, lat, 16);
        if (lat != 0) begin
            check({tag, " sb_size"}, sb.size(), 1);
            if (sb.size() > 0) begin
                last_exp = sb.pop_front();
                check({tag, " decimal_data"}, decimal_data, last_exp.dec);
                check({tag, " accel_data"}, accel_data, last_exp.acc);
                check({tag, " err"}, err, last_exp.err);
                check({tag, " busy_at_done"}, busy, 0);
            end
        end
    endtask

    task automatic after_pulse(input string tag);
        @(negedge clk);
        check({tag, " done_single"}, done, 0);
        check({tag, " dec_held"}, decimal_data, last_exp.dec);
        check({tag, " acc_held"}, accel_data, last_exp.acc);
    endtask

    task automatic run(input string tag, input logic [15:0] d, input logic neg);
        start_conv(tag, d, neg);
        wait_done(tag, 1);
        after_pulse(tag);
        $display("conv %s digits=%h neg=%0d -> dec=0x%03h acc=0x%04h err=%0d",
                 tag, d, neg, decimal_data, accel_data, err);
    endtask

    initial begin
        int extra;
        reset = 1'b1;
        start = 1'b0;
        negative = 1'b0;
        {thousands, hundreds, tens, ones} = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset err", err, 0);
        check("reset dec", decimal_data, 0);
        check("reset acc", accel_data, 0);

        start = 1'b1;
        {thousands, hundreds, tens, ones} = 16'h1000;
        @(negedge clk);
        check("reset_over_start busy", busy, 0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("idle busy", busy, 0);

        run("p1000", 16'h1000, 1'b0);
        check("p1000 exact_dec", decimal_data, 10'h0FA);
        check("p1000 exact_acc", accel_data, 16'h401F);
        run("n2048", 16'h2048, 1'b1);
        check("n2048 exact_acc", accel_data, 16'h0040);
        run("n0004", 16'h0004, 1'b1);
        check("n0004 exact_acc", accel_data, 16'hE07F);
        run("nzero", 16'h0000, 1'b1);
        run("n0003", 16'h0003, 1'b1);
        run("p2047", 16'h2047, 1'b0);
        run("n2051", 16'h2051, 1'b1);
        run("n2052", 16'h2052, 1'b1);
        run("p2048", 16'h2048, 1'b0);
        check("p2048 err_hi", err, 1);
        run("ones_A", 16'h000A, 1'b0);
        run("p9999", 16'h9999, 1'b0);
        run("p0517", 16'h0517, 1'b0);

        // Second start mid-conversion must be ignored.
        start_conv("repulse", 16'h1234, 1'b0);
        repeat (3) @(negedge clk);
        {thousands, hundreds, tens, ones} = 16'h0876;
        negative = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("repulse", 5);
        after_pulse("repulse");
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        check("repulse extra_done", extra, 0);
        $display("conv repulse dec=0x%03h acc=0x%04h err=%0d", decimal_data, accel_data, err);

        // Reset mid-conversion aborts with no done pulse.
        start_conv("abort", 16'h0500, 1'b0);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort err", err, 0);
        check("abort dec", decimal_data, 0);
        check("abort acc", accel_data, 0);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        check("abort no_done", extra, 0);
        sb.delete();
        $display("conv abort reset applied mid-conversion");
        run("post_abort", 16'h0789, 1'b1);

        // Back-to-back: start issued in the done cycle.
        start_conv("b2b_a", 16'h1000, 1'b0);
        wait_done("b2b_a", 1);
        start_conv("b2b_b", 16'h0500, 1'b1);
        check("b2b done_single", done, 0);
        check("b2b a_held_1", decimal_data, last_exp.dec);
        repeat (7) @(negedge clk);
        check("b2b a_held_8", decimal_data, last_exp.dec);
        check("b2b a_acc_held_8", accel_data, last_exp.acc);
        wait_done("b2b_b", 8);
        after_pulse("b2b_b");
        $display("conv b2b second dec=0x%03h acc=0x%04h err=%0d", decimal_data, accel_data, err);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
